// File: rtl/block_serializer.sv
// Block serializer: buffers whole cipher blocks in a small circular store
// and releases them one byte per accepted pacing tick, byte 0 first.
//
// state | meaning
// IDLE  | nothing stored; waiting for the first block
// ARMED | a block is at the head; waiting for a tick while tx is free
// EMIT  | one-cycle strobe of the current byte; advance index / pop head
module block_serializer #(
    parameter int NUM_BYTES = 16,
    parameter int BYTE_W    = 8,
    parameter int DEPTH     = 2,
    localparam int LW       = $clog2(DEPTH) + 1
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               block_valid_in,
    input  logic [NUM_BYTES-1:0][BYTE_W-1:0]   block_in,
    input  logic                               tick_in,
    input  logic                               tx_busy_in,
    output logic [BYTE_W-1:0]                  byte_out,
    output logic                               byte_valid_out,
    output logic                               busy_out,
    output logic [LW-1:0]                      level_out,
    output logic                               overflow_out
);

    localparam int IW = $clog2(NUM_BYTES);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, ARMED, EMIT} state_t;

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]   r_mem [DEPTH];
    logic [NUM_BYTES-1:0][BYTE_W-1:0]   w_head;
    logic [PW-1:0]                      r_wr_ptr;
    logic [PW-1:0]                      r_rd_ptr;
    logic [IW-1:0]                      r_idx;
    logic [LW-1:0]                      r_level;
    logic [LW-1:0]                      w_level_nxt;
    logic [BYTE_W-1:0]                  r_byte;
    logic                               r_valid;
    logic                               r_ovf;
    logic                               w_tick_ok;
    logic                               w_pop;
    logic                               w_push;
    logic                               w_drop;
    logic                               w_load;

    // A full store still accepts a block when the head is popped this cycle,
    // since the popped slot is exactly the one being written.
    assign w_tick_ok = tick_in && !tx_busy_in;
    assign w_pop     = (r_state == EMIT) && (r_idx == LAST_IDX);
    assign w_push    = block_valid_in && ((r_level != FULL) || w_pop);
    assign w_drop    = block_valid_in && !w_push;
    assign w_head    = r_mem[r_rd_ptr];

    assign byte_out       = r_byte;
    assign byte_valid_out = r_valid;
    assign busy_out       = (r_level != '0);
    assign level_out      = r_level;
    assign overflow_out   = r_ovf;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // Next-state decode; w_load marks the tick that launches a byte.
    // IDLE looks at the registered level, so a tick coinciding with the
    // push into an empty store is never honoured.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_level != '0) begin
                    if (w_tick_ok) begin
                        w_state_nxt = EMIT;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ARMED;
                    end
                end
            end
            ARMED: begin
                if (w_tick_ok) begin
                    w_state_nxt = EMIT;
                    w_load      = 1'b1;
                end
            end
            EMIT: begin
                w_state_nxt = (w_pop && (w_level_nxt == '0)) ? IDLE : ARMED;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot storage; contents need no reset.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= block_in;
        end
    end

    // Pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Byte index advances once per emitted byte and wraps on the pop.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_idx <= '0;
        end else if (r_state == EMIT) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    // Output byte is captured on the accepted tick and held until the next.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_byte  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_byte <= w_head[r_idx];
            end
        end
    end

endmodule

// File: doc/block_serializer.md
Name: block_serializer

Overview:
- Converts 128-bit cipher blocks (16 bytes) into a paced byte stream for the tx line transmitter.
- Sits directly downstream of the cipher and upstream of tx.
- Holds up to DEPTH whole blocks so a new cipher result arriving mid-transmission is not lost.
- Emits one byte per pacing tick, which is the 12 kHz single-cycle strobe from the fourth decimation stage.

Parameters:
- NUM_BYTES, 16, bytes per block; index width is $clog2(NUM_BYTES).
- BYTE_W, 8, bits per byte.
- DEPTH, 2, number of whole-block slots; must be a power of 2 and at least 2.

Ports:
- clk_in  input  1  system clock (98.3 MHz).
- rst_in  input  1  asynchronous, active-low reset.
- block_valid_in  input  1  single-cycle strobe; block_in is valid this cycle.
- block_in  input  NUM_BYTES*BYTE_W  packed [NUM_BYTES-1:0][BYTE_W-1:0] block; byte 0 = bits [7:0].
- tick_in  input  1  single-cycle pacing strobe (12 kHz).
- tx_busy_in  input  1  tx is currently shifting a byte out.
- byte_out  output  BYTE_W  byte to transmit.
- byte_valid_out  output  1  single-cycle strobe; byte_out is valid.
- busy_out  output  1  at least one block is stored or in progress.
- level_out  output  $clog2(DEPTH)+1  number of occupied block slots.
- overflow_out  output  1  sticky; an incoming block was dropped.

Behaviour:
- Reset (rst_in=0, asynchronous): all outputs are 0.
  - Write/read pointers, byte index and FSM are cleared; state = IDLE.
  - Slot contents are don't-care.
  - Any block in flight is discarded; no partial byte is emitted after reset deasserts.
- Storage: circular buffer of DEPTH block slots.
  - block_valid_in with level<DEPTH: capture block_in into the write slot, advance the write pointer, level+1 on the next edge.
  - block_valid_in with level==DEPTH and no pop in the same cycle: drop the block, set overflow_out=1 until reset, level unchanged.
- FSM states: IDLE, ARMED, EMIT.
  - IDLE: level==0. Go to ARMED when level becomes nonzero; byte index = 0.
  - ARMED: wait for tick_in.
    - tick_in && !tx_busy_in: go to EMIT.
    - tick_in && tx_busy_in: tick is skipped; stay in ARMED; the byte is not advanced.
  - EMIT (one cycle): byte_out = head_slot[byte_index], byte_valid_out=1.
    - byte_index < NUM_BYTES-1: byte_index+1, back to ARMED.
    - byte_index == NUM_BYTES-1: pop the head slot (level-1), byte_index=0; go to ARMED if remaining level>0, else IDLE.
- Latency and output timing:
  - byte_valid_out asserts exactly one clock after the accepted tick_in.
  - byte_out holds its value until the next emission.
  - byte_valid_out is never high on two consecutive cycles.
- Byte order: index 0 first, through index NUM_BYTES-1.
- Simultaneous events:
  - Push and pop in the same cycle at level==DEPTH: push accepted, no overflow, level unchanged.
  - Push and pop at other levels: level unchanged.
  - A push into an empty buffer never causes emission in the same cycle; at least one tick must follow.
  - tick_in in the same cycle as the push into an empty buffer is ignored.
- busy_out = (level != 0).
- Pointers wrap modulo DEPTH.
- byte_index never exceeds NUM_BYTES-1.
- tick_in while IDLE is ignored.

Test Plan:
- Single block, 0x00..0x0F in bytes 0..15; tick every 100 cycles, tx_busy_in=0.
  - Required: 16 strobes, each 1 cycle after its tick, carrying 0x00,0x01,...,0x0F.
  - Required: level_out goes 1 then 0; busy_out drops after 0x0F.
- Back-to-back blocks: block A pushed, then block B pushed after 5 bytes of A.
  - Required: all of A's bytes, then all of B's bytes; 32 strobes with no gap beyond the tick period; peak level_out=2; overflow_out=0.
- Overflow: push blocks A, B, C with no ticks.
  - Required: level_out=2, overflow_out=1 after C, and stays 1.
  - Required: subsequent ticks emit A then B; C's bytes never appear.
- Push on final-byte pop: level=2, and block C strobes in the same cycle as A's byte 15 emission.
  - Required: C accepted, overflow_out=0, output order A,B,C.
- tx_busy_in held high across 3 ticks mid-block (after byte 0x04).
  - Required: no strobes during those ticks; next unblocked tick emits 0x05; no byte skipped.
- rst_in pulsed low for 2 cycles asynchronously after byte 0x07.
  - Required: all outputs 0 immediately.
  - Required: no strobes on later ticks until a new block arrives, whose byte 0 comes out first.
